// File: rtl/cpu_byte_bridge.sv
// cpu_byte_bridge: splits a 32-bit CPU word access into byte accesses,
// one per enabled lane in ascending order, with a per-lane ack timeout.
// Ports:
//   clk, rst (sync, active-low)
//   CPU side : mem_read, mem_write, mem_byte_enable, mem_address,
//              mem_wdata -> mem_resp, mem_rdata, err
//   Byte side: bmem_req, bmem_we, bmem_addr, bmem_wdata <- bmem_ack,
//              bmem_rdata
module cpu_byte_bridge #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic        bmem_req,
    output logic        bmem_we,
    output logic [31:0] bmem_addr,
    output logic [7:0]  bmem_wdata,
    input  logic        bmem_ack,
    input  logic [7:0]  bmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RESP
    } state_t;

    // Abort fires on the cycle whose count would reach ACK_TIMEOUT,
    // so bmem_req is high for exactly ACK_TIMEOUT cycles.
    localparam logic [7:0] LP_WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [29:0] r_addr;
    logic [3:0]  r_pend;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_lane;
    logic [7:0]  r_wait;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_req;
    logic [3:0]  w_pend_left;
    logic        w_timeout;

    function automatic logic [1:0] f_low_lane(input logic [3:0] i_m);
        logic [1:0] v;
        v = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i_m[i]) begin
                v = 2'(i);
            end
        end
        return v;
    endfunction

    assign w_req       = mem_read | mem_write;
    // Lanes still to service once the current one completes.
    assign w_pend_left = r_pend & ~(4'b0001 << r_lane);
    assign w_timeout   = (r_wait == LP_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_resp    = 1'b0;
        err         = 1'b0;
        bmem_req    = 1'b0;
        bmem_we     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (mem_byte_enable == 4'b0000) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_XFER;
                    end
                end
            end
            S_XFER: begin
                bmem_req = 1'b1;
                bmem_we  = r_we;
                if (bmem_ack) begin
                    if (w_pend_left == 4'b0000) begin
                        w_state_nxt = S_RESP;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                mem_resp    = 1'b1;
                err         = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_pend  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_lane  <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= mem_address[31:2];
                        r_pend  <= mem_byte_enable;
                        r_wdata <= mem_wdata;
                        r_we    <= mem_write;
                        r_lane  <= f_low_lane(mem_byte_enable);
                        r_wait  <= '0;
                        r_err   <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                S_XFER: begin
                    if (bmem_ack) begin
                        if (!r_we) begin
                            r_rdata[{r_lane, 3'b000} +: 8] <= bmem_rdata;
                        end
                        r_pend <= w_pend_left;
                        r_wait <= '0;
                        if (w_pend_left != 4'b0000) begin
                            r_lane <= f_low_lane(w_pend_left);
                        end
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_pend <= '0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rdata  = r_rdata;
    assign bmem_addr  = {r_addr, r_lane};
    assign bmem_wdata = r_wdata[{r_lane, 3'b000} +: 8];

endmodule

// File: tb/tb_cpu_byte_bridge.sv
// Self-checking bench for cpu_byte_bridge: directed table, reset
// corner case and randomized traffic against a transaction-level model.
module tb_cpu_byte_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;
    logic        bmem_req;
    logic        bmem_we;
    logic [31:0] bmem_addr;
    logic [7:0]  bmem_wdata;
    logic        bmem_ack;
    logic [7:0]  bmem_rdata;

    always #5 clk = ~clk;

    cpu_byte_bridge #(.ACK_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .err             (err),
        .bmem_req        (bmem_req),
        .bmem_we         (bmem_we),
        .bmem_addr       (bmem_addr),
        .bmem_wdata      (bmem_wdata),
        .bmem_ack        (bmem_ack),
        .bmem_rdata      (bmem_rdata)
    );

    int nchk = 0;
    int nerr = 0;
    int req_cycles = 0;
    int resp_seen = 0;
    int viol = 0;
    int cnt = 0;
    bit spur = 1'b0;
    logic [7:0]      ovr [logic [31:0]];
    logic [3:0][7:0] lane_wait = '0;
    logic [40:0]     log_q [$];
    logic [40:0]     exp_q [$];

    typedef struct {
        logic            rd;
        logic            wr;
        logic [31:0]     addr;
        logic [3:0]      be;
        logic [31:0]     wd;
        logic [3:0][7:0] w;
        logic [31:0]     e_rd;
        logic            e_er;
        int              e_lat;
        int              e_rq;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Byte memory: acks lane L after lane_wait[L] idle request cycles.
    initial begin
        bmem_ack   = 1'b0;
        bmem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bmem_ack = 1'b0;
            if (bmem_req) begin
                req_cycles++;
                if (cnt >= int'(lane_wait[bmem_addr[1:0]])) begin
                    bmem_ack   = 1'b1;
                    bmem_rdata = rd_byte(bmem_addr);
                    log_q.push_back({bmem_we, bmem_addr,
                                     bmem_we ? bmem_wdata : 8'h00});
                    if (bmem_we) ovr[bmem_addr] = bmem_wdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (spur && $urandom_range(0, 1) == 1) begin
                    bmem_ack   = 1'b1;
                    bmem_rdata = 8'($urandom);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_resp) resp_seen++;
        if (mem_resp && bmem_req) viol++;
    end

    // Transaction-level expectation: lanes ascending, a lane with
    // wait >= TO costs TO cycles, flags err and ends the word.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [3:0][7:0] w,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int rq);
        logic [31:0] a;
        exp_q.delete();
        rd  = '0;
        er  = 1'b0;
        rq  = 0;
        for (int l = 0; l < 4; l++) begin
            if (be[l] && !er) begin
                a = {addr[31:2], 2'(l)};
                if (int'(w[l]) >= TO) begin
                    rq += TO;
                    er = 1'b1;
                end else begin
                    rq += int'(w[l]) + 1;
                    exp_q.push_back({we, a, we ? wd[8*l +: 8] : 8'h00});
                    if (!we) rd[8*l +: 8] = rd_byte(a);
                end
            end
        end
        lat = 1 + rq;
    endtask

    task automatic do_txn(input logic rd_i, input logic wr_i,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd,
                          input logic [3:0][7:0] w, input bit scr,
                          output logic [31:0] a_rd, output logic a_er,
                          output int a_lat, output int a_rq);
        lane_wait = w;
        log_q.delete();
        @(negedge clk);
        req_cycles      = 0;
        mem_read        = rd_i;
        mem_write       = wr_i;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        @(posedge clk);
        a_lat = 0;
        for (int n = 1; n <= 200; n++) begin
            #1;
            if (mem_resp) begin
                a_lat = n;
                break;
            end
            if (scr) begin
                mem_address     = $urandom;
                mem_byte_enable = 4'($urandom);
                mem_wdata       = $urandom;
            end
            @(posedge clk);
        end
        a_rd      = mem_rdata;
        a_er      = err;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", mem_resp, 1'b0);
        chk("err_one_cycle", err, 1'b0);
        chk("rdata_hold", mem_rdata, a_rd);
        a_rq = req_cycles;
    endtask

    task automatic cmp_log(input string nm);
        chk({nm, "_nbytes"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk({nm, "_byte"}, log_q[i], exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]     r_rd, m_rd;
        logic            r_er, m_er;
        int              r_lat, m_lat, r_rq, m_rq;
        logic [3:0][7:0] w;
        int              k;
        bit              found;

        rst             = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address     = '0;
        mem_wdata       = '0;
        ovr[32'h1004]   = 8'h11;
        ovr[32'h1005]   = 8'h22;
        ovr[32'h1006]   = 8'h33;
        ovr[32'h1007]   = 8'h44;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1004, 4'b1111, 32'h0,
                   32'h0000_0000, 32'h4433_2211, 1'b0, 5, 4};
        tbl[1] = '{1'b0, 1'b1, 32'h2000_0003, 4'b0100, 32'hAABB_CCDD,
                   32'h0000_0000, 32'h0000_0000, 1'b0, 2, 1};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0040, 4'b1100, 32'h0,
                   32'h0202_0202, 32'h1918_0000, 1'b0, 7, 6};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h1234_5678,
                   32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0080, 4'b1111, 32'h0,
                   32'h0000_0009, 32'h0000_0000, 1'b1, 5, 4};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0100, 4'b0111, 32'h0,
                   32'h0005_0100, 32'h0000_5A5B, 1'b1, 8, 7};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0300, 4'b1001, 32'h1234_5678,
                   32'h0000_0000, 32'h0000_0000, 1'b0, 3, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_bmem_req", bmem_req, 1'b0);
        chk("rst_bmem_we", bmem_we, 1'b0);
        chk("rst_bmem_addr", bmem_addr, 32'h0);
        chk("rst_bmem_wdata", bmem_wdata, 8'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].w,
                  m_rd, m_er, m_lat, m_rq);
            do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be,
                   tbl[i].wd, tbl[i].w, 1'b0, r_rd, r_er, r_lat, r_rq);
            chk($sformatf("vec%0d_rdata", i), r_rd, tbl[i].e_rd);
            chk($sformatf("vec%0d_err", i), r_er, tbl[i].e_er);
            chk($sformatf("vec%0d_latency", i), r_lat, tbl[i].e_lat);
            chk($sformatf("vec%0d_req_cycles", i), r_rq, tbl[i].e_rq);
            cmp_log($sformatf("vec%0d", i));
        end

        // Reset while lane 2 is outstanding.
        lane_wait = 32'h0009_0000;
        log_q.delete();
        @(negedge clk);
        resp_seen       = 0;
        mem_read        = 1'b1;
        mem_address     = 32'h0000_0500;
        mem_byte_enable = 4'b1111;
        found           = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (bmem_req && bmem_addr[1:0] == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstx_lane2_reached", found, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstx_bmem_req", bmem_req, 1'b0);
        chk("rstx_mem_resp", mem_resp, 1'b0);
        chk("rstx_mem_rdata", mem_rdata, 32'h0);
        chk("rstx_bmem_addr", bmem_addr, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rstx_no_resp", resp_seen, 0);
        w = '0;
        model(1'b0, 32'h0000_0500, 4'b1111, 32'h0, w,
              m_rd, m_er, m_lat, m_rq);
        do_txn(1'b1, 1'b0, 32'h0000_0500, 4'b1111, 32'h0, w, 1'b0,
               r_rd, r_er, r_lat, r_rq);
        chk("rstx_after_rdata", r_rd, m_rd);
        chk("rstx_after_err", r_er, m_er);
        chk("rstx_after_latency", r_lat, m_lat);
        cmp_log("rstx_after");

        // Random traffic with input scrambling and spurious acks.
        spur = 1'b1;
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 2);
            for (int l = 0; l < 4; l++) w[l] = 8'($urandom_range(0, 5));
            mem_address = $urandom;
            mem_byte_enable = 4'($urandom);
            mem_wdata = $urandom;
            model(k != 0, mem_address, mem_byte_enable, mem_wdata, w,
                  m_rd, m_er, m_lat, m_rq);
            do_txn(k != 1, k != 0, mem_address, mem_byte_enable,
                   mem_wdata, w, 1'b1, r_rd, r_er, r_lat, r_rq);
            chk($sformatf("rnd%0d_rdata", t), r_rd, m_rd);
            chk($sformatf("rnd%0d_err", t), r_er, m_er);
            chk($sformatf("rnd%0d_latency", t), r_lat, m_lat);
            chk($sformatf("rnd%0d_req_cycles", t), r_rq, m_rq);
            cmp_log($sformatf("rnd%0d", t));
        end
        spur = 1'b0;

        chk("req_during_resp", viol, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/cpu_byte_bridge.md
CPU_BYTE_BRIDGE -- requirements
Module: cpu_byte_bridge

Interface
REQ-001 Parameter: ACK_TIMEOUT, 255, max cycles one byte transaction may wait for bmem_ack before abort (range 1..255).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the rising clk edge).
REQ-004 mem_read  in  1  CPU read request; held until mem_resp.
REQ-005 mem_write  in  1  CPU write request; held until mem_resp.
REQ-006 mem_byte_enable  in  4  lane enables; bit i = byte lane i of the word.
REQ-007 mem_address  in  32  CPU byte address; bits [1:0] ignored.
REQ-008 mem_wdata  in  32  CPU write data, lane i = bits [8i+7:8i].
REQ-009 mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-010 mem_rdata  out  32  assembled read word.
REQ-011 err  out  1  one-cycle pulse, coincident with mem_resp, on timeout abort.
REQ-012 bmem_req  out  1  byte-memory request, held until acked.
REQ-013 bmem_we  out  1  1 = byte write, 0 = byte read.
REQ-014 bmem_addr  out  32  byte address = {word address, lane[1:0]}.
REQ-015 bmem_wdata  out  8  write byte for current lane.
REQ-016 bmem_ack  in  1  byte-memory completion, sampled on clk edge while bmem_req=1.
REQ-017 bmem_rdata  in  8  read byte, valid when bmem_ack=1.

Function
REQ-018 States SHALL be IDLE, XFER, RESP only.
REQ-019 IDLE: on mem_read=1 or mem_write=1 SHALL latch word address mem_address[31:2], mem_byte_enable, mem_wdata, op (write wins if both high); clear mem_rdata to 0; select lowest enabled lane; go XFER, or RESP directly when byte enable = 0000.
REQ-020 XFER: bmem_req=1, bmem_we=op, bmem_addr={addr[31:2],lane}, bmem_wdata=latched lane byte; outputs stable until ack.
REQ-021 On bmem_ack=1 in XFER: read SHALL write bmem_rdata into mem_rdata lane; then advance to next higher enabled lane, or RESP if none remain.
REQ-022 Lanes SHALL be serviced in ascending order; disabled lanes produce no bmem traffic and read as 0x00.
REQ-023 Wait counter SHALL clear on lane entry and increment each XFER cycle without ack; when it reaches ACK_TIMEOUT the bridge SHALL drop bmem_req, skip remaining lanes, enter RESP with err flagged.
REQ-024 RESP: mem_resp=1 and err (if flagged) for exactly one cycle, then IDLE; mem_rdata held until next request is latched.
REQ-025 CPU request changes during XFER/RESP SHALL be ignored; bmem_ack outside XFER SHALL be ignored.
REQ-026 Latency: mem_resp asserts 1 + sum(cycles per lane) cycles after request sampled in IDLE (zero-wait lane = 1 cycle); be=0000 gives mem_resp 1 cycle after sampling.
REQ-027 bmem_req SHALL never be high in IDLE or RESP; mem_resp never high outside RESP.

Reset
REQ-028 rst=0 SHALL force IDLE; mem_resp=0, err=0, bmem_req=0, bmem_we=0, bmem_addr=0, bmem_wdata=0, mem_rdata=0, wait counter=0, on the next edge regardless of state.
REQ-029 Reset mid-XFER SHALL abandon the transfer with no mem_resp; first request after rst=1 SHALL proceed normally.

Verification
REQ-030 Read 0x0000_1004, be=1111, bytes 11/22/33/44, zero-wait acks -> bmem_addr 0x1004..0x1007, mem_rdata=0x44332211, mem_resp 5 cycles after request sampled, err=0.
REQ-031 Write 0x2000_0003, be=0100, wdata=0xAABBCCDD -> exactly one bmem write addr 0x2000_0002 data 0xBB, then mem_resp.
REQ-032 Read be=1100 at 0x40, ack after 2 wait cycles each -> addrs 0x42,0x43 only, lanes 0/1 of mem_rdata = 0x00, mem_resp 7 cycles after sampling.
REQ-033 Write be=0000 -> no bmem_req, mem_resp 1 cycle after sampling.
REQ-034 ACK_TIMEOUT=4, ack never asserted -> bmem_req high 4 cycles on lane 0, then mem_resp=1 and err=1 same cycle, mem_rdata=0.
REQ-035 rst=0 while lane 2 pending -> next cycle bmem_req=0, no mem_resp; subsequent read completes with correct data.
